// File: rtl/led_pkg.sv
// Shared types for the LED PWM bank: channel mode encoding.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_PWM    = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_OFF    = 2'b11
    } led_mode_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: mode, shadow/active duty and registered output mux.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  led_mode_e           wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    input  logic                period_start,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                blink_on,
    input  logic                direct,
    output logic                led
);

    led_mode_e           mode;
    logic [PWM_BITS-1:0] shadow;
    logic [PWM_BITS-1:0] active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= MODE_DIRECT;
            shadow <= '0;
            active <= '0;
            led    <= 1'b0;
        end else begin
            if (we) begin
                mode   <= wr_mode;
                shadow <= wr_duty;
            end
            // A write landing on the period start wins over the old shadow.
            if (period_start) begin
                active <= we ? wr_duty : shadow;
            end
            unique case (mode)
                MODE_DIRECT: led <= direct;
                MODE_PWM:    led <= (cnt < active);
                MODE_BLINK:  led <= blink_on && (cnt < active);
                MODE_OFF:    led <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/led_pwm_bank.sv
// Bank of LED channels sharing one prescaler, PWM counter and blink timer.
module led_pwm_bank
    import led_pkg::*;
#(
    parameter int N_LEDS        = 8,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 16,
    parameter int BLINK_PERIODS = 64,
    localparam int IDX_W = idx_width(N_LEDS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_LEDS-1:0]   count,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic [N_LEDS-1:0]   led,
    output logic                frame
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

    logic [PS_W-1:0]     presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BL_W-1:0]     blink_cnt;
    logic                blink_on;
    logic                tick;
    logic                period_start;

    assign tick         = (presc == PS_W'(PRESCALE - 1));
    assign period_start = tick && (pwm_cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            frame     <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (period_start) begin
                if (blink_cnt == BL_W'(BLINK_PERIODS - 1)) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            frame <= period_start;
        end
    end

    // Indices at or above N_LEDS match no channel, so such writes fall away.
    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .we           (cfg_we && (cfg_idx == IDX_W'(i))),
            .wr_mode      (led_mode_e'(cfg_mode)),
            .wr_duty      (cfg_duty),
            .period_start (period_start),
            .cnt          (pwm_cnt),
            .blink_on     (blink_on),
            .direct       (count[i]),
            .led          (led[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank with a cycle model feeding a scoreboard.
module tb_led_pwm_bank;
    import led_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] count;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_duty;
    logic [7:0] led;
    logic       frame;

    logic       cfg_we2;
    logic [2:0] cfg_idx2;
    logic [5:0] led2;
    logic       frame2;

    int vectors = 0;
    int errors  = 0;
    int n       = 0;

    led_mode_e  mode_m   [8];
    logic [3:0] shadow_m [8];
    logic [3:0] active_m [8];

    logic [7:0] led_q   [$];
    logic       frame_q [$];
    logic [5:0] led2_q  [$];

    led_pwm_bank #(
        .N_LEDS(8), .PWM_BITS(4), .PRESCALE(2), .BLINK_PERIODS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .count(count),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty), .led(led), .frame(frame)
    );

    led_pwm_bank #(
        .N_LEDS(6), .PWM_BITS(4), .PRESCALE(2), .BLINK_PERIODS(2)
    ) dut6 (
        .clk(clk), .rst_n(rst_n), .count(count[5:0]),
        .cfg_we(cfg_we2), .cfg_idx(cfg_idx2), .cfg_mode(2'b11),
        .cfg_duty(cfg_duty), .led(led2), .frame(frame2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (edge %0d)",
                   tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            mode_m[i]   = MODE_DIRECT;
            shadow_m[i] = '0;
            active_m[i] = '0;
        end
    endtask

    // Counters are derived arithmetically from edges since reset release.
    task automatic step();
        int         pwm;
        bit         ps;
        bit         bon;
        logic [7:0] e;
        pwm = (n / 2) % 16;
        ps  = (n % 2 == 1) && (pwm == 15);
        bon = ((n / 32) / 2) % 2 == 0;
        for (int i = 0; i < 8; i++) begin
            case (mode_m[i])
                MODE_DIRECT: e[i] = count[i];
                MODE_PWM:    e[i] = (pwm < int'(active_m[i]));
                MODE_BLINK:  e[i] = bon && (pwm < int'(active_m[i]));
                default:     e[i] = 1'b0;
            endcase
        end
        led_q.push_back(e);
        frame_q.push_back(ps);
        led2_q.push_back(count[5:0]);
        if (cfg_we) begin
            mode_m[cfg_idx]   = led_mode_e'(cfg_mode);
            shadow_m[cfg_idx] = cfg_duty;
        end
        if (ps) begin
            for (int i = 0; i < 8; i++) active_m[i] = shadow_m[i];
        end
        @(posedge clk);
        #1;
        n++;
        check("led", 32'(led), 32'(led_q.pop_front()));
        check("frame", 32'(frame), 32'(frame_q.pop_front()));
        check("led6", 32'(led2), 32'(led2_q.pop_front()));
    endtask

    task automatic wr(input int idx, input led_mode_e m, input int d);
        cfg_we   = 1'b1;
        cfg_idx  = 3'(idx);
        cfg_mode = m;
        cfg_duty = 4'(d);
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic sync();
        while (n % 32 != 0) step();
    endtask

    task automatic period(input int ch, output int hi);
        hi = 0;
        repeat (32) begin
            step();
            hi += int'(led[ch]);
        end
    endtask

    initial begin
        int hi;
        int tot;
        rst_n    = 1'b0;
        count    = 8'h00;
        cfg_we   = 1'b0;
        cfg_idx  = '0;
        cfg_mode = '0;
        cfg_duty = '0;
        cfg_we2  = 1'b0;
        cfg_idx2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("rst_led", 32'(led), 32'h0);
        check("rst_frame", 32'(frame), 32'h0);
        rst_n = 1'b1;

        count = 8'hA5;
        step();
        count = 8'h3C;
        step();

        wr(3, MODE_PWM, 4);
        sync();
        period(3, hi);
        check("duty4_hi", hi, 8);

        wr(3, MODE_PWM, 0);
        sync();
        period(3, hi);
        check("duty0_hi", hi, 0);

        wr(3, MODE_PWM, 15);
        sync();
        period(3, hi);
        check("duty15_hi", hi, 30);

        wr(3, MODE_PWM, 4);
        sync();
        period(3, hi);
        check("duty4_again", hi, 8);
        hi = 0;
        for (int j = 0; j < 32; j++) begin
            if (j == 13) begin
                wr(3, MODE_PWM, 12);
            end else begin
                count = 8'($urandom);
                step();
            end
            hi += int'(led[3]);
        end
        check("mid_keep", hi, 8);
        period(3, hi);
        check("mid_next", hi, 24);

        while (n % 32 != 31) step();
        wr(3, MODE_PWM, 2);
        period(3, hi);
        check("simul_load", hi, 4);

        wr(5, MODE_BLINK, 15);
        sync();
        tot = 0;
        repeat (4) begin
            period(5, hi);
            tot += hi;
        end
        check("blink_total", tot, 60);

        cfg_we2  = 1'b1;
        cfg_idx2 = 3'd7;
        step();
        cfg_idx2 = 3'd6;
        step();
        cfg_we2  = 1'b0;
        step();

        wr(0, MODE_OFF, 0);
        repeat (150) begin
            count = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                wr($urandom_range(0, 7),
                   led_mode_e'($urandom_range(0, 3)),
                   $urandom_range(0, 15));
            end else begin
                step();
            end
        end

        for (int i = 0; i < 8; i++) wr(i, MODE_DIRECT, 0);
        wr(3, MODE_PWM, 9);
        count = 8'hFF;
        repeat (9) step();
        #3;
        rst_n = 1'b0;
        #1;
        check("amid_led", 32'(led), 32'h0);
        check("amid_frame", 32'(frame), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        repeat (6) begin
            count = 8'($urandom);
            step();
        end
        wr(3, MODE_PWM, 6);
        sync();
        period(3, hi);
        check("post_rst_hi", hi, 12);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
